// File: rtl/audio_pkg.sv
// Shared audio definitions: I2S slot/frame geometry, OSD volume encodings and
// the 17->16 bit saturation used by every mixer in the core.
package audio_pkg;

    localparam int SLOT_BITS  = 16;
    localparam int FRAME_BITS = 32;

    typedef enum logic [1:0] {
        VOL_MUTE = 2'd0,
        VOL_QTR  = 2'd1,
        VOL_HALF = 2'd2,
        VOL_FULL = 2'd3
    } vol_e;

    typedef logic signed [SLOT_BITS-1:0] sample_t;

    // Clamp a 17-bit signed sum into the 16-bit sample range.
    function automatic sample_t sat16(input logic signed [SLOT_BITS:0] x);
        if (x[SLOT_BITS] != x[SLOT_BITS-1]) begin
            sat16 = x[SLOT_BITS] ? sample_t'(16'h8000) : sample_t'(16'h7FFF);
        end else begin
            sat16 = sample_t'(x[SLOT_BITS-1:0]);
        end
    endfunction

    // Half bit-clock period in system clocks (64 half-periods per frame).
    function automatic int unsigned half_div(input int unsigned clk_hz,
                                             input int unsigned sample_rate);
        int unsigned h;
        h = clk_hz / (sample_rate * 64);
        half_div = (h < 1) ? 1 : h;
    endfunction

endpackage

// File: rtl/audio_sample_prep.sv
// Sample preparation: volume scaling, optional saturated mono mix, and the
// one-entry holding register (data plus valid) feeding the I2S serializer.
module audio_sample_prep
    import audio_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        clear,
    input  logic [17:0] audio_l,
    input  logic [17:0] audio_r,
    input  logic [1:0]  volume,
    input  logic        mono,
    output logic [15:0] out_l,
    output logic [15:0] out_r,
    output logic        out_valid
);

    function automatic sample_t scale(input sample_t s, input vol_e v);
        // NOTE: every path assigns the result (default arm included) so no latch is inferred.
        case (v)
            VOL_MUTE: scale = '0;
            VOL_QTR:  scale = s >>> 2;
            VOL_HALF: scale = s >>> 1;
            default:  scale = s;
        endcase
    endfunction

    sample_t                   sl;
    sample_t                   sr;
    sample_t                   mix;
    logic signed [SLOT_BITS:0] sum;

    // The two LSBs of the 18-bit C64 samples are below DAC resolution.
    logic unused_lsbs;
    assign unused_lsbs = ^{audio_l[1:0], audio_r[1:0]};

    always_comb begin
        sl  = scale(sample_t'(audio_l[17:2]), vol_e'(volume));
        sr  = scale(sample_t'(audio_r[17:2]), vol_e'(volume));
        sum = {sl[SLOT_BITS-1], sl} + {sr[SLOT_BITS-1], sr};
        mix = sat16(sum);
    end

    // NOTE: state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (load) begin
                out_l <= mono ? mix : sl;
                out_r <= mono ? mix : sr;
            end
            // A new pair stored in the same cycle the frame consumes the old one keeps the entry full.
            if (load) begin
                out_valid <= 1'b1;
            end else if (clear) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// Philips I2S transmitter for the headphone DAC: bit-clock divider, frame
// counter, holding-register handshake and 32-bit output shift register.
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 31500000,
    parameter int unsigned SAMPLE_RATE = 24000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [17:0] audio_l,
    input  logic [17:0] audio_r,
    input  logic [1:0]  volume,
    input  logic        mono,
    output logic        hp_bck,
    output logic        hp_ws,
    output logic        hp_din,
    output logic        underrun
);

    localparam int unsigned HALF  = half_div(CLK_HZ, SAMPLE_RATE);
    localparam int unsigned DIV_W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [DIV_W-1:0]      div_cnt;
    logic                  bck;
    logic [4:0]            bit_cnt;
    logic [4:0]            bit_nxt;
    logic                  ws_q;
    logic [FRAME_BITS-1:0] shreg;
    logic [SLOT_BITS-1:0]  last_l;
    logic [SLOT_BITS-1:0]  last_r;
    logic [SLOT_BITS-1:0]  hold_l;
    logic [SLOT_BITS-1:0]  hold_r;
    logic                  full;
    logic                  div_tc;
    logic                  fall_evt;
    logic                  frame_load;
    logic                  accept;

    assign div_tc     = (div_cnt == DIV_W'(HALF - 1));
    assign fall_evt   = div_tc && bck;
    assign frame_load = fall_evt && (bit_cnt == 5'd31);
    assign bit_nxt    = bit_cnt + 5'd1;
    assign in_ready   = !full || frame_load;
    assign accept     = in_valid && in_ready;

    assign hp_bck = bck;
    assign hp_ws  = ws_q;
    assign hp_din = shreg[FRAME_BITS-1];

    audio_sample_prep u_prep (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (accept),
        .clear     (frame_load),
        .audio_l   (audio_l),
        .audio_r   (audio_r),
        .volume    (volume),
        .mono      (mono),
        .out_l     (hold_l),
        .out_r     (hold_r),
        .out_valid (full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bck     <= 1'b0;
        end else if (div_tc) begin
            div_cnt <= '0;
            bck     <= ~bck;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Frame state moves only on bck falling, so ws/din are stable across every rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt  <= 5'd31;
            ws_q     <= 1'b0;
            shreg    <= '0;
            last_l   <= '0;
            last_r   <= '0;
            underrun <= 1'b0;
        end else begin
            underrun <= frame_load && !full;
            if (fall_evt) begin
                bit_cnt <= bit_nxt;
                // WS leads the slot by one bit: high for the last left bit through the second-last right bit.
                ws_q    <= (bit_nxt >= 5'd15) && (bit_nxt <= 5'd30);
                if (frame_load) begin
                    if (full) begin
                        shreg  <= {hold_l, hold_r};
                        last_l <= hold_l;
                        last_r <= hold_r;
                    end else begin
                        shreg  <= {last_l, last_r};
                    end
                end else begin
                    shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed bench for audio_i2s_tx: a scoreboard of expected frame words is
// filled as pairs are accepted and drained by an I2S bit-level monitor.
module tb_audio_i2s_tx;

    localparam int          CLK_HZ      = 31500000;
    localparam int          SAMPLE_RATE = 24000;
    localparam int          HALF        = CLK_HZ / (SAMPLE_RATE * 64);
    localparam logic [31:0] WS_PATTERN  = 32'h0001_FFFE;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] audio_l  = '0;
    logic [17:0] audio_r  = '0;
    logic [1:0]  volume   = '0;
    logic        mono     = 1'b0;
    logic        hp_bck;
    logic        hp_ws;
    logic        hp_din;
    logic        underrun;

    int          n_cmp       = 0;
    int          n_bad       = 0;
    int          mon_b       = -1;
    int          frames_done = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    audio_i2s_tx #(
        .CLK_HZ      (CLK_HZ),
        .SAMPLE_RATE (SAMPLE_RATE)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .audio_l  (audio_l),
        .audio_r  (audio_r),
        .volume   (volume),
        .mono     (mono),
        .hp_bck   (hp_bck),
        .hp_ws    (hp_ws),
        .hp_din   (hp_din),
        .underrun (underrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Samples the I2S lines on each bck rise, locks onto the WS falling edge,
    // then checks every frame against the scoreboard.
    task automatic monitor();
        int          cyc       = 0;
        int          last_rise = 0;
        int          und_cnt   = 0;
        logic        prev_bck  = 1'b0;
        logic        prev_ws   = 1'b0;
        logic        in_frame  = 1'b0;
        logic        exp_under = 1'b0;
        logic [31:0] last_exp  = '0;
        logic [31:0] data_w    = '0;
        logic [31:0] ws_w      = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                mon_b    = -1;
                prev_bck = 1'b0;
                prev_ws  = 1'b0;
                und_cnt  = 0;
                in_frame = 1'b0;
                last_exp = '0;
                exp_q.delete();
            end else begin
                if (underrun) und_cnt++;
                if (!prev_bck && hp_bck) begin
                    if (mon_b >= 0) begin
                        check("bck_period", 32'(cyc - last_rise), 32'(2 * HALF));
                        mon_b = (mon_b + 1) % 32;
                    end else if (prev_ws && !hp_ws) begin
                        mon_b   = 31;
                        und_cnt = 0;
                    end
                    last_rise = cyc;
                    if (mon_b == 0) begin
                        exp_under = (exp_q.size() == 0);
                        if (!exp_under) last_exp = exp_q.pop_front();
                        check("underrun_pulses", 32'(und_cnt), exp_under ? 32'd1 : 32'd0);
                        und_cnt  = 0;
                        in_frame = 1'b1;
                        data_w   = '0;
                        ws_w     = '0;
                    end
                    if (in_frame) begin
                        data_w = {data_w[30:0], hp_din};
                        ws_w   = {ws_w[30:0], hp_ws};
                    end
                    if (mon_b == 31 && in_frame) begin
                        check("frame_data", data_w, last_exp);
                        check("frame_ws", ws_w, WS_PATTERN);
                        frames_done++;
                    end
                    prev_ws = hp_ws;
                end
                prev_bck = hp_bck;
            end
        end
    endtask

    // Waits until the monitor enters bit b of a fresh bit period.
    task automatic wait_bit(input int b);
        int n = 0;
        while (mon_b == b && n < 4000) begin @(negedge clk); #1; n++; end
        while (mon_b != b && n < 4000) begin @(negedge clk); #1; n++; end
        if (n >= 4000) check("wait_bit_timeout", 32'(mon_b), 32'(b));
    endtask

    task automatic wait_frames(input int n);
        int target = frames_done + n;
        int cyc    = 0;
        while (frames_done < target && cyc < (n + 2) * 64 * HALF) begin
            @(negedge clk); #1; cyc++;
        end
        if (frames_done < target) check("frame_timeout", 32'(frames_done), 32'(target));
    endtask

    // Presents a pair and pushes its expected frame word when it is accepted.
    task automatic send(input logic [17:0] l, input logic [17:0] r, input logic [1:0] vol,
                        input logic mix, input logic [31:0] exp_w, input bit keep, input bit at_load);
        int waited = 0;
        audio_l  = l;
        audio_r  = r;
        volume   = vol;
        mono     = mix;
        in_valid = 1'b1;
        while (!in_ready && waited < 3000) begin @(negedge clk); #1; waited++; end
        check("ready_gap_within_frame", 32'(waited <= 64 * HALF), 32'd1);
        if (in_ready) begin
            if (at_load) check("accept_at_load", {26'd0, hp_bck, 5'(mon_b)}, {26'd0, 1'b1, 5'd31});
            exp_q.push_back(exp_w);
        end
        @(negedge clk); #1;
        if (!keep) in_valid = 1'b0;
    endtask

    initial begin
        int n;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        #1;
        check("rst_bck", 32'(hp_bck), 32'd0);
        check("rst_ws", 32'(hp_ws), 32'd0);
        check("rst_din", 32'(hp_din), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_underrun", 32'(underrun), 32'd0);
        reset_n = 1'b1;

        // Idle: zeros with one underrun pulse per frame.
        wait_frames(2);

        wait_bit(4); send(18'h0A000, 18'h3F000, 2'd3, 1'b0, 32'h2800_FC00, 1'b0, 1'b0);
        wait_bit(4); send(18'h1FFFC, 18'h1FFFC, 2'd3, 1'b1, 32'h7FFF_7FFF, 1'b0, 1'b0);
        wait_bit(4); send(18'h20000, 18'h20000, 2'd3, 1'b1, 32'h8000_8000, 1'b0, 1'b0);
        wait_bit(4); send(18'h3FFFC, 18'h10000, 2'd1, 1'b0, 32'hFFFF_1000, 1'b0, 1'b0);
        wait_bit(4); send(18'h0A000, 18'h3F000, 2'd0, 1'b0, 32'h0000_0000, 1'b0, 1'b0);

        // Continuous valid: after the first, every acceptance lands on a frame load.
        wait_bit(4);
        for (int k = 0; k < 5; k++) begin
            logic [15:0] l16;
            logic [15:0] r16;
            l16 = 16'h1234 + 16'(k);
            r16 = 16'h8765 - 16'(k);
            send({l16, 2'b01}, {r16, 2'b10}, 2'd3, 1'b0, {l16, r16}, k < 4, k > 0);
        end
        wait_frames(3);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // Mid-frame asynchronous reset at bit 20 of a frame with right[11] set.
        wait_bit(4); send(18'h0A000, 18'h3F000, 2'd3, 1'b0, 32'h2800_FC00, 1'b0, 1'b0);
        wait_frames(1);
        wait_bit(20);
        check("pre_rst_bck", 32'(hp_bck), 32'd1);
        check("pre_rst_ws", 32'(hp_ws), 32'd1);
        check("pre_rst_din", 32'(hp_din), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_bck", 32'(hp_bck), 32'd0);
        check("mid_rst_ws", 32'(hp_ws), 32'd0);
        check("mid_rst_din", 32'(hp_din), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_underrun", 32'(underrun), 32'd0);
        repeat (5) @(negedge clk);
        #1;
        reset_n = 1'b1;
        n = 0;
        while (n < 200) begin
            @(negedge clk); #1; n++;
            if (underrun) break;
        end
        check("first_underrun_delay", 32'(n), 32'(2 * HALF));
        check("first_frame_bck", 32'(hp_bck), 32'd0);
        check("first_frame_din", 32'(hp_din), 32'd0);
        wait_frames(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
